// File: rtl/serial_sequence_generator_if.sv
// Request/stream bundle of the serial sequence generator: parallel pattern
// request on the input side, one-bit serial stream on the output side.
interface serial_sequence_generator_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 4
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               in_valid;
    logic               in_ready;
    logic [MAX_LEN-1:0] in_pattern;
    logic [LEN_W-1:0]   in_len;
    logic [CNT_W-1:0]   in_repeat;
    logic               out_valid;
    logic               out_ready;
    logic               out_bit;
    logic               done;

    // Producer of requests and consumer of the serial stream.
    modport master (
        output in_valid, in_pattern, in_len, in_repeat, out_ready,
        input  in_ready, out_valid, out_bit, done
    );

    // The generator itself.
    modport slave (
        input  in_valid, in_pattern, in_len, in_repeat, out_ready,
        output in_ready, out_valid, out_bit, done
    );
endinterface

// File: rtl/serial_sequence_generator.sv
// Serial bit-pattern transmitter: shifts a left-aligned pattern out MSB-first,
// repeating it back-to-back in_repeat extra times, under consumer backpressure.
module serial_sequence_generator #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 4
) (
    input logic                     clk,
    input logic                     rst,
    serial_sequence_generator_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_LEN   = LEN_W'(1);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_reg,   state_next;
    logic [MAX_LEN-1:0] shift_reg,   shift_next;
    logic [MAX_LEN-1:0] reload_reg,  reload_next;
    logic [LEN_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [LEN_W-1:0]   len_reg,     len_next;
    logic [CNT_W-1:0]   rep_cnt_reg, rep_cnt_next;

    logic [LEN_W-1:0]   eff_len;
    logic [LEN_W-1:0]   align_amt;
    logic [MAX_LEN-1:0] aligned;
    logic [MAX_LEN-1:0] shifted;
    logic               beat;
    logic               last_bit;
    logic               final_beat;

    // Zero or oversized lengths fall back to a full-width pattern.
    always_comb begin
        eff_len = bus.in_len;
        if (bus.in_len == '0 || bus.in_len > MAX_LEN_L) begin
            eff_len = MAX_LEN_L;
        end
    end

    assign align_amt = MAX_LEN_L - eff_len;
    assign aligned   = bus.in_pattern << align_amt;

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shifted[gi] = 1'b0;
            end else begin : g_mid
                assign shifted[gi] = shift_reg[gi-1];
            end
        end
    endgenerate

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == SEND);
    assign bus.out_bit   = (state_reg == SEND) & shift_reg[MAX_LEN-1];

    assign beat       = bus.out_valid & bus.out_ready;
    assign last_bit   = (bit_cnt_reg == ONE_LEN);
    assign final_beat = beat & last_bit & (rep_cnt_reg == '0);
    assign bus.done   = final_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            reload_reg  <= '0;
            bit_cnt_reg <= '0;
            len_reg     <= '0;
            rep_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            reload_reg  <= reload_next;
            bit_cnt_reg <= bit_cnt_next;
            len_reg     <= len_next;
            rep_cnt_reg <= rep_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        reload_next  = reload_reg;
        bit_cnt_next = bit_cnt_reg;
        len_next     = len_reg;
        rep_cnt_next = rep_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    shift_next   = aligned;
                    reload_next  = aligned;
                    bit_cnt_next = eff_len;
                    len_next     = eff_len;
                    rep_cnt_next = bus.in_repeat;
                    state_next   = SEND;
                end
            end
            SEND: begin
                if (beat) begin
                    if (!last_bit) begin
                        shift_next   = shifted;
                        bit_cnt_next = bit_cnt_reg - ONE_LEN;
                    end else if (rep_cnt_reg != '0) begin
                        // Reload on the last beat so repetitions run without a gap.
                        shift_next   = reload_reg;
                        bit_cnt_next = len_reg;
                        rep_cnt_next = rep_cnt_reg - ONE_CNT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_serial_sequence_generator.sv
// Scoreboard bench for serial_sequence_generator: expected beats are queued when
// a request is driven and consumed by a monitor on every accepted output beat.
module tb_serial_sequence_generator;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   txn_cnt = 0;
    int   txn_beats = 0;
    exp_t exp_q[$];

    serial_sequence_generator_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    serial_sequence_generator #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted beat is checked against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            txn_beats = 0;
        end else if (bus.out_valid && bus.out_ready) begin
            txn_beats++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_beat: got bit=%0b done=%0b, required no beat", bus.out_bit, bus.done);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (bus.out_bit !== e.b) begin
                    bad++;
                    $display("FAIL beat_bit: got %0b, required %0b (beat %0d)", bus.out_bit, e.b, txn_beats);
                end
                total++;
                if (bus.done !== e.last) begin
                    bad++;
                    $display("FAIL beat_done: got %0b, required %0b (beat %0d)", bus.done, e.last, txn_beats);
                end
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                txn_cnt++;
                $display("txn %0d complete: %0d beats", txn_cnt, txn_beats);
                txn_beats = 0;
            end
        end else begin
            total++;
            if (bus.done !== 1'b0) begin
                bad++;
                $display("FAIL idle_done: got %0b, required 0 without a beat", bus.done);
            end
            if (!bus.out_valid) begin
                total++;
                if (bus.out_bit !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_bit: got %0b, required 0 while out_valid=0", bus.out_bit);
                end
            end
        end
    end

    // Drive one request (accepted at the next edge) and queue its expected beats.
    task automatic start(input logic [7:0] pat, input int len, input int rep);
        int   eff;
        exp_t e;
        eff = (len == 0 || len > MAX_LEN) ? MAX_LEN : len;
        bus.in_valid   = 1'b1;
        bus.in_pattern = pat;
        bus.in_len     = LEN_W'(len);
        bus.in_repeat  = CNT_W'(rep);
        for (int r = 0; r <= rep; r++) begin
            for (int i = eff - 1; i >= 0; i--) begin
                e.b    = pat[i];
                e.last = (r == rep) && (i == 0);
                exp_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(output int cycles, output bit ok);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
        end
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.out_bit, bus.done} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_during: got rdy/val/bit/done=%b, required 1000",
                     {bus.in_ready, bus.out_valid, bus.out_bit, bus.done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.out_bit, bus.done} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_after: got rdy/val/bit/done=%b, required 1000",
                     {bus.in_ready, bus.out_valid, bus.out_bit, bus.done});
        end
    endtask

    task automatic test_basic();
        int cycles; bit ok; int d0;
        d0 = done_cnt;
        start(8'b0011_0011, 6, 0);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_bit !== 1'b1 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_first: got val=%0b bit=%0b rdy=%0b, required 1 1 0",
                     bus.out_valid, bus.out_bit, bus.in_ready);
        end
        wait_drain(cycles, ok);
        total++;
        if (!ok || cycles != 6) begin
            bad++;
            $display("FAIL basic_len: got %0d cycles (drained=%0b), required 6", cycles, ok);
        end
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_ready: got rdy=%0b val=%0b, required 1 0", bus.in_ready, bus.out_valid);
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL basic_done_count: got %0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_repeat();
        int cycles; bit ok; int d0;
        d0 = done_cnt;
        start(8'b0000_1010, 4, 2);
        wait_drain(cycles, ok);
        total++;
        if (!ok || cycles != 12) begin
            bad++;
            $display("FAIL repeat_len: got %0d cycles (drained=%0b), required 12", cycles, ok);
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL repeat_done_count: got %0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int cycles; bit ok; int d0; logic held;
        d0 = done_cnt;
        start(8'b0011_0011, 6, 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        held = bus.out_bit;
        total++;
        if (held !== exp_q[0].b) begin
            bad++;
            $display("FAIL stall_bit: got %0b, required %0b", held, exp_q[0].b);
        end
        @(posedge clk); #1;
        total++;
        if (bus.out_bit !== held || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold: got bit=%0b val=%0b, required bit=%0b val=1", bus.out_bit, bus.out_valid, held);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        total++;
        if (bus.out_bit !== held) begin
            bad++;
            $display("FAIL stall_hold2: got %0b, required %0b", bus.out_bit, held);
        end
        wait_drain(cycles, ok);
        total++;
        if (!ok || cycles + 3 != 8) begin
            bad++;
            $display("FAIL stall_len: got %0d cycles (drained=%0b), required 8", cycles + 3, ok);
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL stall_done_count: got %0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_len_clamp();
        int cycles; bit ok;
        for (int k = 0; k < 2; k++) begin
            start(8'hA5, (k == 0) ? 0 : MAX_LEN + 1, 0);
            wait_drain(cycles, ok);
            total++;
            if (!ok || cycles != 8) begin
                bad++;
                $display("FAIL clamp_len%0d: got %0d cycles (drained=%0b), required 8", k, cycles, ok);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cycles; bit ok; int d0;
        d0 = done_cnt;
        start(8'b0011_0011, 6, 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.out_bit, bus.done} !== 4'b1000) begin
            bad++;
            $display("FAIL abort_state: got rdy/val/bit/done=%b, required 1000",
                     {bus.in_ready, bus.out_valid, bus.out_bit, bus.done});
        end
        total++;
        if (exp_q.size() != 3 || done_cnt != d0) begin
            bad++;
            $display("FAIL abort_progress: got %0d left, %0d done, required 3 left, 0 done",
                     exp_q.size(), done_cnt - d0);
        end
        exp_q.delete();
        start(8'h3C, 8, 1);
        wait_drain(cycles, ok);
        total++;
        if (!ok || cycles != 16 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL abort_resend: got %0d cycles, %0d done, required 16 cycles, 1 done",
                     cycles, done_cnt - d0);
        end
    endtask

    task automatic test_ignore_in_send();
        int cycles; bit ok;
        start(8'b0011_0011, 6, 0);
        @(posedge clk); #1;
        bus.in_valid   = 1'b1;
        bus.in_pattern = 8'hFF;
        bus.in_len     = LEN_W'(8);
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ignore_ready: got %0b, required 0", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_drain(cycles, ok);
        total++;
        if (!ok || cycles + 2 != 6) begin
            bad++;
            $display("FAIL ignore_len: got %0d cycles (drained=%0b), required 6", cycles + 2, ok);
        end
    endtask

    task automatic test_back_to_back();
        int cycles; bit ok; int d0;
        d0 = done_cnt;
        start(8'b0000_0101, 3, 0);
        wait_drain(cycles, ok);
        start(8'b0000_0010, 2, 1);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_bit !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: got val=%0b bit=%0b, required 1 1", bus.out_valid, bus.out_bit);
        end
        wait_drain(cycles, ok);
        total++;
        if (!ok || cycles != 4 || done_cnt - d0 != 2) begin
            bad++;
            $display("FAIL b2b_len: got %0d cycles, %0d done, required 4 cycles, 2 done",
                     cycles, done_cnt - d0);
        end
    endtask

    task automatic test_random();
        int cycles; int d0;
        d0 = done_cnt;
        for (int n = 0; n < 6; n++) begin
            start(8'($urandom), $urandom_range(0, MAX_LEN + 1), $urandom_range(0, 2));
            cycles = 0;
            while (exp_q.size() != 0 && cycles < 600) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
                cycles++;
            end
            bus.out_ready = 1'b1;
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL random_timeout: got %0d beats left, required 0", exp_q.size());
                exp_q.delete();
            end
        end
        total++;
        if (done_cnt - d0 != 6) begin
            bad++;
            $display("FAIL random_done_count: got %0d, required 6", done_cnt - d0);
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_pattern = '0;
        bus.in_len     = '0;
        bus.in_repeat  = '0;
        bus.out_ready  = 1'b1;
        test_reset();
        test_basic();
        test_repeat();
        test_backpressure();
        test_len_clamp();
        test_reset_mid();
        test_ignore_in_send();
        test_back_to_back();
        test_random();
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
